ext_out_uart_tx: RTL and testbench

- Downstream consumer of the CPU external output byte. It replaces raw parallel observation of the output port with a serial line.
- The CPU writeback stage presents a byte and a one-cycle strobe on every OUT instruction. The block queues the byte in a small FIFO and serialises it as an 8N1 UART frame, LSB first.
- The block sits between the CPU top level and the board pin. It has backpressure visibility only; the CPU does not stall on it.

---
 rtl/cpu_io_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/ext_out_uart_tx.sv | 145 ++++++++++++++
 tb/tb_ext_out_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Purpose: shared types and constants for the CPU external-output UART path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_io_pkg;

    // Transmitter FSM state; busy is simply "state != IDLE".
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // 8N1 frame: one low start bit, eight data bits LSB first, one high stop bit.
    localparam logic START_BIT       = 1'b0;
    localparam logic STOP_BIT        = 1'b1;
    localparam int   DATA_BITS       = 8;

    localparam int   DEFAULT_CLK_DIV = 16;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: small synchronous FIFO that queues CPU output bytes ahead of the serialiser.
// Latency: a pushed byte is visible on dout one cycle after the push edge when the FIFO was empty.
// Backpressure: push is ignored when full, pop is ignored when empty; the caller reads full/empty.
// Ports: clk, rst (async active-low), push/din, pop/dout, count, full, empty.
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_W-1:0]           din,
    input  logic                        pop,
    output logic [DATA_W-1:0]           dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int               PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because the depth is a power of two; the
    // count, not the pointers, tells full apart from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ext_out_uart_tx.sv
// Purpose: queues CPU OUT bytes and serialises them as 8N1 UART frames, LSB first.
// Latency: strobe in cycle N into an idle, empty block drives the start bit from cycle N+2.
// Backpressure: none towards the CPU; full is visible, and a strobe while full is dropped and sets sticky overflow.
// Ports: clk, rst (async active-low), out_data/out_valid from writeback, tx line, busy, fifo_full, fifo_count, overflow.
module ext_out_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = DATA_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           out_data,
    input  logic                        out_valid,
    output logic                        tx,
    output logic                        busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              baud_last;

    // Fullness is judged on the pre-edge state, so a pop on the same edge
    // does not rescue a strobe that arrives while full.
    assign fifo_push  = out_valid && !fifo_full;
    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
    assign overflow_d = overflow_q || (out_valid && fifo_full);

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (out_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = START;
                    shift_d = fifo_dout;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge as the state, keeping busy and tx aligned.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= STOP_BIT;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ext_out_uart_tx.sv
// Purpose: directed self-checking bench for ext_out_uart_tx at CLK_DIV=4, FIFO_DEPTH=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_ext_out_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_GAP  = 10 * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] out_data;
    logic       out_valid;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [8:0] rx_q[$];
    int         start_q[$];

    ext_out_uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge and present this cycle's inputs.
    task automatic drive_cycle(input logic vld, input logic [7:0] dat);
        @(negedge clk);
        out_valid = vld;
        out_data  = vld ? dat : 8'($urandom);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            drive_cycle(1'b0, 8'h00);
            k++;
        end
        check_eq("rx_frame_count", rx_q.size(), n);
    endtask

    // Line monitor: decodes frames by mid-bit sampling and logs start cycles.
    initial begin : rx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                rx_q.push_back({tx, b});
            end
        end
    end

    initial begin : stim
        logic [7:0] v;
        logic [7:0] tbl [12];
        logic [7:0] sb[$];
        logic       exp_tx;
        logic [8:0] got;

        tbl = '{8'h00, 8'hFF, 8'h5A, 8'h80, 8'h01, 8'hC3,
                8'h7E, 8'h10, 8'hEF, 8'h33, 8'h96, 8'h08};

        // ---------------- reset state
        rst       = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", fifo_full, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ovf", overflow, 0);
        rst = 1'b1;
        repeat (3) drive_cycle(1'b0, 8'h00);
        check_eq("post_rst_tx", tx, 1);
        check_eq("post_rst_busy", busy, 0);

        // ---------------- single byte 0xA5, cycle-exact waveform
        v = 8'hA5;
        drive_cycle(1'b1, v);
        check_eq("single_c0_tx", tx, 1);
        for (int c = 1; c <= 45; c++) begin
            drive_cycle(1'b0, 8'h00);
            if (c < 2)       exp_tx = 1'b1;
            else if (c <= 5) exp_tx = 1'b0;
            else if (c <= 37) exp_tx = v[(c - 6) / 4];
            else             exp_tx = 1'b1;
            check_eq($sformatf("single_tx_c%0d", c), tx, exp_tx);
            check_eq($sformatf("single_busy_c%0d", c), busy, (c >= 2 && c <= 41));
            if (c == 1) check_eq("single_count_c1", fifo_count, 1);
            if (c == 2) check_eq("single_count_c2", fifo_count, 0);
        end
        check_eq("single_ovf", overflow, 0);
        rx_q.delete();
        start_q.delete();

        // ---------------- burst of 5
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'(i + 1));
            if (i == 2) check_eq("burst_busy_c2", busy, 1);
            if (i >= 1) check_eq($sformatf("burst_count_c%0d", i), fifo_count, (i == 1) ? 1 : i - 1);
        end
        drive_cycle(1'b0, 8'h00);
        check_eq("burst_count_c5", fifo_count, 4);
        check_eq("burst_full_c5", fifo_full, 1);
        check_eq("burst_ovf", overflow, 0);
        wait_rx(5, 400);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check_eq($sformatf("burst_byte%0d", i), rx_q[i], {1'b1, 8'(i + 1)});
            if (i > 0) check_eq($sformatf("burst_gap%0d", i), start_q[i] - start_q[i-1], FRAME_GAP);
        end
        repeat (10) drive_cycle(1'b0, 8'h00);
        check_eq("burst_idle_busy", busy, 0);
        rx_q.delete();
        start_q.delete();

        // ---------------- overflow: six strobes, sixth dropped
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(i + 1));
        check_eq("ovf_before", overflow, 0);
        check_eq("ovf_full_c5", fifo_full, 1);
        drive_cycle(1'b0, 8'h00);
        check_eq("ovf_set", overflow, 1);
        check_eq("ovf_count_c6", fifo_count, 4);
        wait_rx(5, 400);
        repeat (60) drive_cycle(1'b0, 8'h00);
        check_eq("ovf_only5", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check_eq($sformatf("ovf_byte%0d", i), rx_q[i], {1'b1, 8'(i + 1)});
        check_eq("ovf_sticky", overflow, 1);
        rx_q.delete();
        start_q.delete();

        // ---------------- reset mid-frame (DATA bit 3 of 0x11 is 0)
        drive_cycle(1'b1, 8'h11);
        drive_cycle(1'b1, 8'h22);
        drive_cycle(1'b1, 8'h33);
        for (int c = 3; c <= 19; c++) drive_cycle(1'b0, 8'h00);
        check_eq("mid_count_pre", fifo_count, 2);
        check_eq("mid_tx_pre", tx, 0);
        check_eq("mid_busy_pre", busy, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_tx_async", tx, 1);
        check_eq("mid_count_async", fifo_count, 0);
        check_eq("mid_busy_async", busy, 0);
        check_eq("mid_ovf_cleared", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            drive_cycle(1'b0, 8'h00);
            check_eq($sformatf("mid_idle_tx_c%0d", c), tx, 1);
        end
        check_eq("mid_idle_busy", busy, 0);
        rx_q.delete();
        start_q.delete();

        // ---------------- push/pop collision then 12-byte scoreboard run
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, tbl[i]);
            sb.push_back(tbl[i]);
        end
        for (int c = 3; c <= 41; c++) drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, tbl[3]);
        sb.push_back(tbl[3]);
        check_eq("coll_count_c42", fifo_count, 2);
        check_eq("coll_busy_c42", busy, 0);
        drive_cycle(1'b0, 8'h00);
        check_eq("coll_count_c43", fifo_count, 2);
        check_eq("coll_busy_c43", busy, 1);
        for (int i = 4; i < 12; i++) begin
            repeat (45) drive_cycle(1'b0, 8'h00);
            drive_cycle(1'b1, tbl[i]);
            sb.push_back(tbl[i]);
        end
        wait_rx(12, 900);
        for (int i = 0; i < 12 && rx_q.size() > 0; i++) begin
            got = rx_q.pop_front();
            check_eq($sformatf("sb_byte%0d", i), got, {1'b1, sb[i]});
        end
        check_eq("sb_no_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
